// File: rtl/definitions.sv
// Shared core definitions: opcode encodings plus branch sequencer state and depth width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package definitions;

  localparam int BRANCH_DEPTH_W = 8;

  typedef enum logic [3:0] {
    NOP   = 4'h0,
    INC   = 4'h1,
    DEC   = 4'h2,
    LEFT  = 4'h3,
    RIGHT = 4'h4,
    OUT   = 4'h5,
    IN    = 4'h6,
    CBF   = 4'h7,
    CBB   = 4'h8,
    HALT  = 4'hf
  } op_code;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } branch_state_e;

endpackage

// File: rtl/branch_depth_counter.sv
// Bracket nesting-depth counter: load to 1, step up/down, flag next-zero and overflow.
// Latency: count updates on the next clock; zero/overflow are combinational on this cycle's inc/dec.
// Backpressure: none; caller only asserts inc/dec on accepted fetches.
// Ports: clock/reset, load (depth=1), inc, dec; zero = depth becomes 0 this cycle,
//        overflow = inc requested while depth is already all-ones (count saturates).
module branch_depth_counter
  import definitions::*;
#(
  parameter int DEPTH_W = BRANCH_DEPTH_W
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic overflow
);

  logic [DEPTH_W-1:0] count;

  // Both flags look at the value the count is about to take, so the FSM can
  // act on the match/overflow in the same cycle the opcode is fetched.
  assign overflow = inc && (count == {DEPTH_W{1'b1}});
  assign zero     = dec && !inc && (count == DEPTH_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= DEPTH_W'(1);
    end else if (inc && !dec) begin
      if (!overflow) count <= count + DEPTH_W'(1);
    end else if (dec && !inc) begin
      count <= count - DEPTH_W'(1);
    end
  end

endmodule

// File: rtl/branch_scan_sequencer.sv
// Resolves CBF/CBB by scanning program memory for the matching bracket and returning a PC write.
// Latency: not-taken 1 cycle; taken N+1 cycles for N scanned opcodes, plus one per fetch wait cycle.
// Backpressure: fetch_req/fetch_addr held until fetch_valid; core stalled via busy while scanning.
// Ports: start/instruction/acc_zero/pc_in issue a branch; fetch_* is the scan read port;
//        busy/done/pc_write/pc_out report completion; error flags an unmatched or too-deep scan.
module branch_scan_sequencer
  import definitions::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = BRANCH_DEPTH_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  op_code            instruction,
  input  logic              acc_zero,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_valid,
  input  op_code            fetch_data,
  output logic              busy,
  output logic              done,
  output logic              pc_write,
  output logic [ADDR_W-1:0] pc_out,
  output logic              error
);

  branch_state_e state;
  logic          scan_back;  // 1: CBB scanning toward address 0

  logic issue_ok, taken, issue_back, issue_at_limit;
  logic scan_hit, same_kind, opp_kind, at_limit;
  logic depth_load, depth_inc, depth_dec, depth_zero, depth_ovf;

  assign issue_ok       = start && ((state == IDLE) || (state == FAULT));
  assign issue_back     = (instruction == CBB);
  assign taken          = ((instruction == CBF) && acc_zero) || ((instruction == CBB) && !acc_zero);
  // A taken branch sitting on the address limit would have to wrap for its first fetch.
  assign issue_at_limit = issue_back ? (pc_in == '0) : (pc_in == {ADDR_W{1'b1}});

  assign scan_hit  = (state == SCAN) && fetch_req && fetch_valid;
  assign same_kind = (fetch_data == (scan_back ? CBB : CBF));
  assign opp_kind  = (fetch_data == (scan_back ? CBF : CBB));
  assign at_limit  = scan_back ? (fetch_addr == '0) : (fetch_addr == {ADDR_W{1'b1}});

  assign depth_load = issue_ok && taken;
  assign depth_inc  = scan_hit && same_kind;
  assign depth_dec  = scan_hit && opp_kind;

  branch_depth_counter #(.DEPTH_W(DEPTH_W)) u_depth (
    .clock    (clock),
    .reset    (reset),
    .load     (depth_load),
    .inc      (depth_inc),
    .dec      (depth_dec),
    .zero     (depth_zero),
    .overflow (depth_ovf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      scan_back  <= 1'b0;
      fetch_req  <= 1'b0;
      fetch_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pc_write   <= 1'b0;
      pc_out     <= '0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, FAULT: begin
          if (start) begin
            error    <= 1'b0;
            done     <= 1'b0;
            pc_write <= 1'b0;
            if (taken && issue_at_limit) begin
              state <= FAULT;
              error <= 1'b1;
              busy  <= 1'b0;
            end else if (taken) begin
              state      <= SCAN;
              scan_back  <= issue_back;
              fetch_req  <= 1'b1;
              fetch_addr <= issue_back ? pc_in - ADDR_W'(1) : pc_in + ADDR_W'(1);
              busy       <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end

        SCAN: begin
          if (scan_hit) begin
            if (depth_ovf) begin
              state     <= FAULT;
              fetch_req <= 1'b0;
              busy      <= 1'b0;
              error     <= 1'b1;
            end else if (depth_zero) begin
              state     <= DONE;
              fetch_req <= 1'b0;
              done      <= 1'b1;
              pc_write  <= 1'b1;
              pc_out    <= fetch_addr + ADDR_W'(1);
            end else if (at_limit) begin
              state     <= FAULT;
              fetch_req <= 1'b0;
              busy      <= 1'b0;
              error     <= 1'b1;
            end else begin
              fetch_addr <= scan_back ? fetch_addr - ADDR_W'(1) : fetch_addr + ADDR_W'(1);
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          pc_write <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_scan_sequencer.sv
// Directed bench for branch_scan_sequencer against a small zero/variable-wait program memory.
// Latency: n/a (testbench).
// Backpressure: memory model stretches each fetch by wait_cycles cycles.
module tb_branch_scan_sequencer;
  import definitions::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  op_code       instruction;
  logic         acc_zero;
  logic [15:0]  pc_in;
  logic         fetch_req;
  logic [15:0]  fetch_addr;
  logic         fetch_valid;
  op_code       fetch_data;
  logic         busy, done, pc_write, error;
  logic [15:0]  pc_out;

  int errors = 0;
  int checks = 0;

  op_code mem [0:255];
  logic   ovf_mode = 1'b0;
  int     wait_cycles = 0;
  int     wait_cnt = 0;

  always #5 clock = ~clock;

  branch_scan_sequencer #(.ADDR_W(16), .DEPTH_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .acc_zero    (acc_zero),
    .pc_in       (pc_in),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .busy        (busy),
    .done        (done),
    .pc_write    (pc_write),
    .pc_out      (pc_out),
    .error       (error)
  );

  // Program memory: low 8 address bits index the table; overflow mode returns CBF everywhere.
  always_comb begin
    fetch_data = NOP;
    if (ovf_mode) fetch_data = CBF;
    else          fetch_data = mem[fetch_addr[7:0]];
  end

  assign fetch_valid = fetch_req && (wait_cnt >= wait_cycles);

  always @(posedge clock) begin
    if (!fetch_req || fetch_valid) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a branch for one cycle (cycle 0); returns positioned in cycle 1.
  task automatic issue(input op_code op, input logic az, input logic [15:0] pc);
    start = 1'b1; instruction = op; acc_zero = az; pc_in = pc;
    step();
    start = 1'b0; instruction = NOP;
  endtask

  initial begin
    int cyc;
    bit seen_done;
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[8'h10] = CBF; mem[8'h11] = NOP; mem[8'h12] = CBF;
    mem[8'h13] = CBB; mem[8'h14] = CBB; mem[8'h15] = NOP;

    reset = 1'b1; start = 1'b0; instruction = NOP; acc_zero = 1'b0; pc_in = '0;
    #3;
    chk("rst_outputs", {fetch_req, busy, done, pc_write, error}, 5'b0);
    chk("rst_addrs", {fetch_addr, pc_out}, 32'h0);
    @(negedge clock) reset = 1'b0;
    step();

    // Taken CBF from 0x10; a stray start mid-scan must be ignored.
    issue(CBF, 1'b1, 16'h0010);
    chk("cbf_c1_req", {fetch_req, busy}, 2'b11);
    chk("cbf_c1_addr", fetch_addr, 16'h0011);
    start = 1'b1; instruction = NOP;
    step(); start = 1'b0;
    chk("cbf_c2_addr", fetch_addr, 16'h0012);
    step(); step();
    chk("cbf_c4_notdone", {done, fetch_req}, 2'b01);
    step();
    chk("cbf_c5_done", {done, pc_write, busy, fetch_req}, 4'b1110);
    chk("cbf_c5_pc", pc_out, 16'h0015);
    step();
    chk("cbf_c6_idle", {done, pc_write, busy}, 3'b000);

    // Taken CBB from 0x14.
    issue(CBB, 1'b0, 16'h0014);
    chk("cbb_c1_addr", fetch_addr, 16'h0013);
    step(); step(); step();
    chk("cbb_c4_addr", {done, fetch_addr}, {1'b0, 16'h0010});
    step();
    chk("cbb_c5_done", {done, pc_write}, 2'b11);
    chk("cbb_c5_pc", pc_out, 16'h0011);
    step();

    // Not-taken CBF and a plain NOP: done one cycle later, no fetch.
    issue(CBF, 1'b0, 16'h0010);
    chk("nt_cbf_c1", {done, pc_write, busy, fetch_req}, 4'b1010);
    step();
    chk("nt_cbf_c2", {done, busy}, 2'b00);
    issue(NOP, 1'b1, 16'h0010);
    chk("nop_c1", {done, pc_write, fetch_req}, 3'b100);
    step();

    // Two wait cycles per fetch.
    wait_cycles = 2;
    issue(CBF, 1'b1, 16'h0010);
    step();
    chk("wait_c2_hold", {fetch_req, fetch_addr}, {1'b1, 16'h0011});
    step();
    chk("wait_c3_hold", fetch_addr, 16'h0011);
    step();
    chk("wait_c4_next", fetch_addr, 16'h0012);
    for (int i = 5; i <= 12; i++) step();
    chk("wait_c12_notdone", done, 1'b0);
    step();
    chk("wait_c13_done", {done, pc_write}, 2'b11);
    chk("wait_c13_pc", pc_out, 16'h0015);
    step();
    wait_cycles = 0;

    // Backward scan runs off address 0.
    issue(CBB, 1'b0, 16'h0002);
    chk("bfault_c1_addr", fetch_addr, 16'h0001);
    step();
    chk("bfault_c2_addr", {error, fetch_addr}, {1'b0, 16'h0000});
    step();
    chk("bfault_c3_err", {error, done, pc_write, fetch_req}, 4'b1000);
    step();
    chk("bfault_hold", {error, done}, 2'b10);
    issue(NOP, 1'b0, 16'h0000);
    chk("bfault_clear", {error, done}, 2'b01);
    step();

    // Forward scan runs off the all-ones address.
    issue(CBF, 1'b1, 16'hfffd);
    step(); step();
    chk("ffault_c3_err", {error, done, fetch_req}, 3'b100);
    issue(CBF, 1'b1, 16'h0010);
    chk("ffault_restart", {error, fetch_req, fetch_addr}, {2'b01, 16'h0011});
    step(); step(); step(); step();
    chk("ffault_restart_done", {done, pc_out}, {1'b1, 16'h0015});
    step();

    // Depth overflow: every fetched opcode is another CBF.
    ovf_mode = 1'b1;
    issue(CBF, 1'b1, 16'h0100);
    cyc = 1; seen_done = 1'b0;
    while (!error && cyc < 400) begin
      if (done) seen_done = 1'b1;
      step();
      cyc++;
    end
    chk("ovf_cycle", cyc, 256);
    chk("ovf_state", {error, seen_done, fetch_req, pc_write}, 4'b1000);
    ovf_mode = 1'b0;
    issue(NOP, 1'b0, 16'h0000);
    step();

    // Asynchronous reset at cycle 2 of a scan.
    issue(CBF, 1'b1, 16'h0010);
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_flags", {fetch_req, busy, done, pc_write, error}, 5'b0);
    chk("rst_mid_addrs", {fetch_addr, pc_out}, 32'h0);
    @(negedge clock) reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("rst_mid_nodone", seen_done, 1'b0);
    issue(CBF, 1'b1, 16'h0010);
    step(); step(); step();
    step();
    chk("rst_fresh_done", {done, pc_write, pc_out}, {2'b11, 16'h0015});
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
